// File: rtl/dual_rail_receiver_if.sv
// Channel-side rails plus the word-level valid/ready port of the dual-rail receiver.
// Latency: none, wires only.
// Backpressure: out_ready from the consumer; ackt back to the transmitter.
interface dual_rail_receiver_if #(
   parameter int WIDTH = 8
);
   logic             bitt1;
   logic             bitt2;
   logic             ackt;
   logic [WIDTH-1:0] data_out;
   logic             out_valid;
   logic             out_ready;
   logic             err;
   logic             par_err;

   // transmitter + consumer side
   modport master (
      output bitt1, bitt2, out_ready,
      input  ackt, data_out, out_valid, err, par_err
   );

   // receiver side
   modport slave (
      input  bitt1, bitt2, out_ready,
      output ackt, data_out, out_valid, err, par_err
   );
endinterface

// File: rtl/dual_rail_receiver.sv
// Dual-rail four-phase bit receiver: syncs rails, decodes one bit per handshake, packs LSB-first words.
// Latency: rail edge -> ackt edge = SYNC_STAGES+1 clk; last bit ack -> out_valid one clk later.
// Backpressure: a completed word waiting on a full output stalls the channel (ackt held low).
// Optional parity bit per word enabled by macro DUAL_RAIL_PARITY_CHECK_EN.
module dual_rail_receiver #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   dual_rail_receiver_if.slave  bus
);

`ifdef DUAL_RAIL_PARITY_CHECK_EN
   localparam int NBITS = WIDTH + 1;
`else
   localparam int NBITS = WIDTH;
`endif
   localparam int CW = $clog2(NBITS + 1);

   typedef enum logic {IDLE, ACK} state_t;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] sync0, sync1;
   logic                   r0, r1;
   logic [NBITS-1:0]       shreg;
   logic [CW-1:0]          cnt;
   logic                   full;
   logic                   take_bit;
   logic                   take_bad;
   logic                   load;
   logic [WIDTH-1:0]       data_q;
   logic                   valid_q;
   logic                   err_q;

   assign r0   = sync0[SYNC_STAGES-1];
   assign r1   = sync1[SYNC_STAGES-1];
   assign full = (cnt == CW'(NBITS));
   // hand the assembled word over whenever the output slot is free or being drained
   assign load = full && (!valid_q || bus.out_ready);

   // rail synchronisers, one shift chain per rail
   always_ff @(posedge clk) begin
      if (rst) begin
         sync0 <= '0;
         sync1 <= '0;
      end else begin
         sync0 <= {sync0[SYNC_STAGES-2:0], bus.bitt1};
         sync1 <= {sync1[SYNC_STAGES-2:0], bus.bitt2};
      end
   end

   // handshake FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // handshake FSM: next state and token decode; no token taken while a word is stuck
   always_comb begin
      state_nxt = state;
      take_bit  = 1'b0;
      take_bad  = 1'b0;
      case (state)
         IDLE: begin
            if (!full) begin
               if (r0 ^ r1) begin
                  take_bit  = 1'b1;
                  state_nxt = ACK;
               end else if (r0 && r1) begin
                  take_bad  = 1'b1;
                  state_nxt = ACK;
               end
            end
         end
         ACK: begin
            if (!r0 && !r1) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // bit assembly: shift decoded bit into its slot, clear count on hand-off
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg <= '0;
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= take_bad;
         if (load) begin
            cnt <= '0;
         end else if (take_bit) begin
            for (int i = 0; i < NBITS; i++) begin
               if (cnt == CW'(i)) shreg[i] <= r1;
            end
            cnt <= cnt + CW'(1);
         end
      end
   end

`ifdef DUAL_RAIL_PARITY_CHECK_EN
   logic perr_q;

   // output word register; load beats a simultaneous consume
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
      end else if (load) begin
         data_q  <= shreg[WIDTH-1:0];
         valid_q <= 1'b1;
         perr_q  <= ^shreg;
      end else if (valid_q && bus.out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.par_err = perr_q;
`else
   // output word register; load beats a simultaneous consume
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (load) begin
         data_q  <= shreg[WIDTH-1:0];
         valid_q <= 1'b1;
      end else if (valid_q && bus.out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.par_err = 1'b0;
`endif

   // ackt is exactly "in ACK"; the state is registered so ackt is too
   assign bus.ackt      = (state == ACK);
   assign bus.data_out  = data_q;
   assign bus.out_valid = valid_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_dual_rail_receiver.sv
// Directed bench for dual_rail_receiver with a word-level scoreboard model.
// Latency: checks SYNC_STAGES+1 clk for every accepted rail edge.
// Backpressure: exercises output hold and channel stall via out_ready.
module tb_dual_rail_receiver;
   localparam int WIDTH = 8;
   localparam int SS    = 2;
`ifdef DUAL_RAIL_PARITY_CHECK_EN
   localparam int NB = WIDTH + 1;
`else
   localparam int NB = WIDTH;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dual_rail_receiver_if #(.WIDTH(WIDTH)) bus ();

   dual_rail_receiver #(.WIDTH(WIDTH), .SYNC_STAGES(SS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   // model state: bits of the word in flight, expected words {par_err, data}
   logic             cur_bits[$];
   logic [WIDTH:0]   exp_q[$];
   logic [WIDTH-1:0] last_word = '0;
   logic             last_perr = 1'b0;
   int               consumed  = 0;
   int               err_seen  = 0;
   int               illegal_n = 0;
   logic             err_prev  = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ackt(input logic lvl, input int limit, input string tag, output int edges);
      edges = 0;
      while (bus.ackt !== lvl && edges < limit) begin
         tick();
         edges++;
      end
      if (bus.ackt !== lvl) check({tag, " ackt timeout"}, int'(bus.ackt), int'(lvl));
   endtask

   // word-level model: collect bits, emit a word once NB bits arrived
   task automatic model_push(input logic b);
      logic [WIDTH-1:0] w;
      logic             p;
      cur_bits.push_back(b);
      if (cur_bits.size() == NB) begin
         w = '0;
         p = 1'b0;
         for (int i = 0; i < NB; i++) begin
            if (i < WIDTH) w[i] = cur_bits[i];
            p = p ^ cur_bits[i];
         end
`ifndef DUAL_RAIL_PARITY_CHECK_EN
         p = 1'b0;
`endif
         exp_q.push_back({p, w});
         cur_bits.delete();
      end
   endtask

   task automatic send_bit(input logic b, input bit illegal, input string tag);
      int e;
      wait_ackt(1'b0, 50, {tag, " idle"}, e);
      if (illegal) begin
         bus.bitt1 = 1'b1;
         bus.bitt2 = 1'b1;
      end else begin
         bus.bitt1 = ~b;
         bus.bitt2 = b;
      end
      wait_ackt(1'b1, 20, tag, e);
      check({tag, " rise latency"}, e, SS + 1);
      if (illegal) begin
         check({tag, " err pulse"}, int'(bus.err), 1);
         illegal_n++;
      end else begin
         model_push(b);
      end
      bus.bitt1 = 1'b0;
      bus.bitt2 = 1'b0;
      wait_ackt(1'b0, 20, tag, e);
      check({tag, " fall latency"}, e, SS + 1);
   endtask

   task automatic send_word(input logic [WIDTH-1:0] w, input string tag);
      for (int i = 0; i < WIDTH; i++) send_bit(w[i], 1'b0, tag);
   endtask

   // compare process: every consume must match the model's next word
   always @(negedge clk) begin
      logic [WIDTH:0] e;
      if (!rst) begin
         if (bus.err) begin
            err_seen++;
            check("err width", int'(err_prev), 0);
         end
         err_prev = bus.err;
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected word", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("word data", int'(bus.data_out), int'(e[WIDTH-1:0]));
               check("word par_err", int'(bus.par_err), int'(e[WIDTH]));
               last_word = bus.data_out;
               last_perr = bus.par_err;
               consumed++;
            end
         end
      end else begin
         err_prev = 1'b0;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] w96;
      int         e;
      int         highs;

      // T1 reset
      rst           = 1'b1;
      bus.bitt1     = 1'b0;
      bus.bitt2     = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      check("rst ackt",      int'(bus.ackt), 0);
      check("rst out_valid", int'(bus.out_valid), 0);
      check("rst data_out",  int'(bus.data_out), 0);
      check("rst err",       int'(bus.err), 0);
      check("rst par_err",   int'(bus.par_err), 0);
      rst = 1'b0;
      tick();

      // T2 plain word
      send_word(8'hA5, "t2");
      repeat (3) tick();
      check("t2 word", int'(last_word), 'hA5);

      // T3 backpressure: one word held, one stuck, next bit must stall
      bus.out_ready = 1'b0;
      send_word(8'h3C, "t3a");
      send_word(8'h55, "t3b");
      w96       = 8'h96;
      bus.bitt1 = ~w96[0];
      bus.bitt2 = w96[0];
      highs = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.ackt) highs++;
      end
      check("t3 stall ackt", highs, 0);
      check("t3 held valid", int'(bus.out_valid), 1);
      check("t3 held data", int'(bus.data_out), 'h3C);
      bus.out_ready = 1'b1;
      wait_ackt(1'b1, 10, "t3 resume", e);
      check("t3 resume bound", int'(e <= SS + 1), 1);
      model_push(w96[0]);
      bus.bitt1 = 1'b0;
      bus.bitt2 = 1'b0;
      wait_ackt(1'b0, 20, "t3 resume", e);
      for (int i = 1; i < WIDTH; i++) send_bit(w96[i], 1'b0, "t3c");
      repeat (3) tick();
      check("t3 last word", int'(last_word), 'h96);

      // T4 illegal token then a clean word
      send_bit(1'b0, 1'b1, "t4 bad");
      check("t4 err cleared", int'(bus.err), 0);
      send_word(8'h0F, "t4");
      repeat (3) tick();
      check("t4 word", int'(last_word), 'h0F);

      // T5 reset in the middle of the 4th handshake
      send_bit(1'b1, 1'b0, "t5p");
      send_bit(1'b1, 1'b0, "t5p");
      send_bit(1'b0, 1'b0, "t5p");
      bus.bitt2 = 1'b1;
      wait_ackt(1'b1, 20, "t5 4th", e);
      rst = 1'b1;
      tick();
      check("t5 ackt dropped", int'(bus.ackt), 0);
      bus.bitt2 = 1'b0;
      repeat (3) tick();
      check("t5 data_out", int'(bus.data_out), 0);
      check("t5 out_valid", int'(bus.out_valid), 0);
      rst = 1'b0;
      cur_bits.delete();
      tick();
      send_word(8'h81, "t5");
      repeat (3) tick();
      check("t5 word", int'(last_word), 'h81);

`ifdef DUAL_RAIL_PARITY_CHECK_EN
      // T6 parity: 0x07 has odd weight, so good parity bit is 1
      send_word(8'h07, "t6a");
      send_bit(1'b1, 1'b0, "t6a par");
      repeat (3) tick();
      check("t6 good parity", int'(last_perr), 0);
      send_word(8'h07, "t6b");
      send_bit(1'b0, 1'b0, "t6b par");
      repeat (3) tick();
      check("t6 bad parity", int'(last_perr), 1);
      check("t6 word", int'(last_word), 'h07);
`endif

      repeat (5) tick();
      check("queue drained", exp_q.size(), 0);
      check("err count", err_seen, illegal_n);
`ifdef DUAL_RAIL_PARITY_CHECK_EN
      check("words consumed", consumed, 8);
`else
      check("words consumed", consumed, 6);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
